rr_port_arbiter: RTL and testbench
==================================

// Module: rr_port_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one W-bit pass-through channel among NREQ requesters.
//   Registered one-hot grant selects which requester's data drives the shared output y.
//   While no grant is held, y carries the parameterised DEFAULT value.
//   A bounded hold counter forces rotation so no requester can starve the others.
//   Feeds a downstream pass-through consumer whose idle input value must be well defined.
//
// PARAMETERS
//   NREQ      4   number of requesters, >= 1
//   W         4   channel data width, >= 1
//   DEFAULT   6   value driven on y when no grant is active; truncated to W bits
//   MAX_HOLD  3   max consecutive grant cycles per tenure; 0 disables the timeout
//
// PORTS
//   clk    input   1       clock, all state updates on posedge
//   rst    input   1       asynchronous, active-high reset
//   req    input   NREQ    request vector; port default '0 (instance may omit it)
//   data   input   NREQ*W  packed per-requester data, requester i at [i*W +: W]
//   gnt    output  NREQ    registered one-hot grant, all-zero when idle
//   y      output  W       shared channel: data of granted requester, else DEFAULT
//   busy   output  1       1 while any grant bit is set (== |gnt)
//
// BEHAVIOUR
// - Reset (async, dominates every other event): state=IDLE, gnt=0, ptr=0, cnt=0.
//   Outputs during and after reset: y=DEFAULT, busy=0.
// - y is combinational from the gnt register: y = data[g*W +: W] when gnt[g]=1, else DEFAULT.
//   There is no extra pipeline stage on data.
// - Arbitration pick(p): first index i scanning p, p+1, ... NREQ-1, 0, ... with req[i]=1.
// - Grant latency: req sampled at edge k; gnt visible after edge k (1 cycle).
// - IDLE state:
//   - req==0: remain IDLE.
//   - Otherwise: GRANT, g=pick(ptr), cnt=1.
// - GRANT state, holder g; release occurs if req[g]=0, or MAX_HOLD!=0 and cnt==MAX_HOLD:
//   - No release: keep g, cnt++ (cnt saturates at MAX_HOLD, never wraps).
//   - On release: ptr = (g+1) mod NREQ. If another req is set, switch directly to pick((g+1) mod NREQ).
//     The switch has no idle bubble, and cnt=1.
//   - Timeout release with req[g] still 1 and no other requester: g is re-granted, cnt=1.
//     gnt never deasserts in this case.
//   - Release with req==0: IDLE, gnt=0, y returns to DEFAULT on the same edge.
//   - req[g] drop and timeout on the same cycle: handled as a single release, same rules.
// - ptr wrap-around: ptr = NREQ-1 releases to 0; the modulo applies for non-power-of-2 NREQ.
// - NREQ=1: ptr stays 0; grant held while req[0]=1; timeout re-grants without a gap.
// - Requests are level-sensitive; a req that drops before being granted is not remembered.
// - Invariant: $onehot0(gnt) every cycle.
// - Invariant: busy == |gnt.
// - Invariant: gnt[i] implies req[i] was 1 at the previous edge.
// - Reset mid-tenure: gnt clears asynchronously; the next grant after reset starts from ptr=0.
// - No latches, no X on outputs once rst has been asserted.
//
// TESTING  (NREQ=4, W=4, DEFAULT=6, MAX_HOLD=3)
// - req port omitted, rst pulsed -> gnt===0, busy===0, y===6 for 10 cycles.
// - req=4'b0001, data[3:0]=9 from cycle 0 -> gnt=0001 after edge 1.
//   y===9; gnt stays 0001 (timeout re-grants req0, never deasserts).
// - req=4'b1010 held steady -> grants 0010, 0010, 0010, 1000, 1000, 1000, 0010 (3-cycle tenures).
//   y alternates data1/data3; no idle cycle at any switch.
// - Holder 3 releases with req=4'b0101 -> next grant 0001 (wrap), then 0100 after its tenure.
// - req=4'b0001 then dropped after 1 granted cycle -> gnt=0 next edge, y===6.
// - rst asserted mid-grant between edges -> gnt===0, y===6 immediately.
//   After release with req=4'b1111 -> first grant 0001.

Source files
------------

// File: rtl/rr_port_arbiter_if.sv
// Shared-channel bundle: requesters drive req/data, the arbiter returns grant and the muxed channel.
interface rr_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  // Requesters that never drive req read as idle.
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      y;
  logic              busy;

  modport master (output req, data, input gnt, y, busy);
  modport slave  (input req, data, output gnt, y, busy);
endinterface

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one W-bit channel; grant registered 1 cycle after req,
// y combinational from the grant register, bounded tenure forces rotation.
module rr_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 4,
  parameter int DEFAULT  = 6,
  parameter int MAX_HOLD = 3
) (
  input  logic             clk,
  input  logic             rst,
  rr_port_arbiter_if.slave bus
);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [W-1:0]    DEF_Y   = W'(DEFAULT);
  localparam logic [CW-1:0]   CNT_SAT = (MAX_HOLD > 0) ? CW'(MAX_HOLD) : {CW{1'b1}};
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  // Pointer kept one-hot so the scan start becomes a mask instead of an index.
  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ptr;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_ptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            w_keep;
  logic            w_timeout;
  logic            w_release;
  logic [NREQ-1:0] w_ptr_rel;
  logic [NREQ-1:0] w_pick_ptr;
  logic [NREQ-1:0] w_pick_rel;
  logic [W-1:0]    w_y;
  logic            w_busy;

  // First set bit at or above the start position, else first set bit overall.
  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [NREQ-1:0] p_oh);
    logic [NREQ-1:0] hi;
    hi = r & ~(p_oh - ONE);
    if (|hi) return hi & (~hi + ONE);
    return r & (~r + ONE);
  endfunction

  assign w_keep     = |(bus.req & r_gnt);
  assign w_timeout  = (MAX_HOLD != 0) && (r_cnt == CNT_SAT);
  assign w_release  = !w_keep || w_timeout;
  assign w_ptr_rel  = (r_gnt << 1) | (r_gnt >> (NREQ - 1));
  assign w_pick_ptr = pick(bus.req, r_ptr);
  assign w_pick_rel = pick(bus.req, w_ptr_rel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= ONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = w_pick_ptr;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_ptr_rel;
          // A lone timed-out holder is re-picked here, so the grant never gaps.
          if (|bus.req) begin
            w_gnt_nxt = w_pick_rel;
            w_cnt_nxt = CW'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_y = DEF_Y;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_y = bus.data[i*W +: W];
    end
    w_busy = |r_gnt;
  end

  assign bus.gnt  = r_gnt;
  assign bus.y    = w_y;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter (NREQ=4, W=4, DEFAULT=6, MAX_HOLD=3).
module tb_rr_port_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam logic [15:0] DATA = 16'h3C59;  // d3=3 d2=C d1=5 d0=9

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_port_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  rr_port_arbiter #(.NREQ(NREQ), .W(W), .DEFAULT(6), .MAX_HOLD(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] y_of(input logic [3:0] g);
    case (g)
      4'b0001: return 4'h9;
      4'b0010: return 4'h5;
      4'b0100: return 4'hC;
      4'b1000: return 4'h3;
      default: return 4'h6;
    endcase
  endfunction

  task automatic test_reset();
    logic [8:0] obs, exp;
    bus.data = DATA;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {bus.gnt, bus.busy, bus.y};
    exp = {4'b0000, 1'b0, 4'h6};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL in_reset: got gnt/busy/y=%b, need %b", obs, exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {bus.gnt, bus.busy, bus.y};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL idle_no_req[%0d]: got gnt/busy/y=%b, need %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_single_timeout();
    logic [8:0] obs, exp;
    bus.req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {bus.gnt, bus.busy, bus.y};
      exp = {4'b0001, 1'b1, 4'h9};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL single_hold[%0d]: got gnt/busy/y=%b, need %b", i, obs, exp);
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
    obs = {bus.gnt, bus.busy, bus.y};
    exp = {4'b0000, 1'b0, 4'h6};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL single_release: got gnt/busy/y=%b, need %b", obs, exp);
    end
  endtask

  task automatic test_rotation();
    logic [8:0] obs, exp;
    logic [3:0] rot_a [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                               4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    logic [3:0] rot_b [7]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
                               4'b0100, 4'b0001};
    bus.req = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {bus.gnt, bus.busy, bus.y};
      exp = {rot_a[i], 1'b1, y_of(rot_a[i])};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL rot_1010[%0d]: got gnt/busy/y=%b, need %b", i, obs, exp);
      end
    end
    // Holder 3 drops: next pick wraps to requester 0.
    bus.req = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      obs = {bus.gnt, bus.busy, bus.y};
      exp = {rot_b[i], 1'b1, y_of(rot_b[i])};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL rot_wrap[%0d]: got gnt/busy/y=%b, need %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_drop();
    logic [8:0] obs, exp;
    logic [3:0] req_v [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] gnt_v [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      bus.req = req_v[i];
      @(negedge clk);
      obs = {bus.gnt, bus.busy, bus.y};
      exp = {gnt_v[i], |gnt_v[i], y_of(gnt_v[i])};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL drop[%0d]: got gnt/busy/y=%b, need %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] obs, exp;
    logic [3:0] post [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    bus.req = 4'b1111;
    @(negedge clk);
    obs = {bus.gnt, bus.busy, bus.y};
    exp = {4'b0010, 1'b1, 4'h5};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL pre_reset_grant: got gnt/busy/y=%b, need %b", obs, exp);
    end
    #2 rst = 1'b1;
    #1;
    obs = {bus.gnt, bus.busy, bus.y};
    exp = {4'b0000, 1'b0, 4'h6};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_reset: got gnt/busy/y=%b, need %b", obs, exp);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.busy, bus.y} !== exp) begin
      n_err++;
      $display("FAIL reset_held: got gnt/busy/y=%b, need %b", {bus.gnt, bus.busy, bus.y}, exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obs = {bus.gnt, bus.busy, bus.y};
      exp = {post[i], 1'b1, y_of(post[i])};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL post_reset[%0d]: got gnt/busy/y=%b, need %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_timeout();
    test_rotation();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
